pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 96 +++++++++
 tb/tb_pipe_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined carry-segmented adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves one carry segment; all result bits of a beat leave together.
module pipe_adder #(
   parameter int WIDTH  = 114,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);
   localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

   logic             stall;
   logic [STAGES:0]  vld_p;
   logic [WIDTH-1:0] a_p   [STAGES];
   logic [WIDTH-1:0] b_p   [STAGES];
   logic             cy_p  [STAGES+1];
   logic [WIDTH-1:0] ps_p  [1:STAGES];
   logic [WIDTH:0]   seg_r [1:STAGES];

   // Adds one segment in place: returns {carry_out, segment bits at their own position}.
   // A segment that starts past the top bit is empty and passes the carry through.
   function automatic logic [WIDTH:0] seg_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin,
                                              input int               idx);
      int               lo;
      int               hi;
      logic [WIDTH-1:0] m;
      logic [WIDTH:0]   t;
      logic [WIDTH:0]   tc;
      lo = idx * SEG;
      hi = (lo + SEG < WIDTH) ? lo + SEG : WIDTH;
      if (hi < lo)
         hi = lo;
      m  = ({WIDTH{1'b1}} << lo) & ~({WIDTH{1'b1}} << hi);
      t  = {1'b0, (x & m) >> lo} + {1'b0, (y & m) >> lo} + {{WIDTH{1'b0}}, cin};
      tc = t >> (hi - lo);
      return {tc[0], (t[WIDTH-1:0] << lo) & m};
   endfunction

   assign stall     = vld_p[STAGES] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld_p[STAGES];
   assign sum       = {cy_p[STAGES], ps_p[STAGES]};

   // Stage 1..STAGES: segment s-1 plus the sum bits already resolved upstream
   always_comb begin
      for (int s = 1; s <= STAGES; s++) begin
         seg_r[s] = seg_add(a_p[s-1], b_p[s-1], cy_p[s-1], s - 1);
         if (s > 1)
            seg_r[s][WIDTH-1:0] = seg_r[s][WIDTH-1:0] | ps_p[(s > 1) ? s - 1 : 1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         vld_p <= '0;
      else if (!stall)
         vld_p <= {vld_p[STAGES-1:0], in_valid};
   end

   // Stage 0 registers the beat; subtraction is folded in as ~b with carry-in 1,
   // so the sub bit rides with its beat through the inverted operand and the carry chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         cy_p[STAGES] <= 1'b0;
         ps_p[STAGES] <= '0;
      end else if (!stall) begin
         if (in_valid) begin
            a_p[0]  <= a;
            b_p[0]  <= sub ? ~b : b;
            cy_p[0] <= sub;
         end
         for (int s = 1; s < STAGES; s++) begin
            if (vld_p[s-1]) begin
               a_p[s] <= a_p[s-1];
               b_p[s] <= b_p[s-1];
            end
         end
         for (int s = 1; s <= STAGES; s++) begin
            if (vld_p[s-1]) begin
               cy_p[s] <= seg_r[s][WIDTH];
               ps_p[s] <= seg_r[s][WIDTH-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: several WIDTH/STAGES builds run side by side,
// each with directed corner beats, stalls, resets in flight and random traffic.
module tb_pipe_adder;
   localparam int NCFG = 11;
   localparam int NCYC = 2000;

   function automatic int cfg_w(int i);
      case (i)
         0: return 114;
         1: return 8;
         2: return 2;
         3: return 2;
         4: return 17;
         5: return 17;
         6: return 17;
         7: return 114;
         8: return 114;
         9: return 114;
         default: return 5;
      endcase
   endfunction

   function automatic int cfg_s(int i);
      case (i)
         0: return 4;
         1: return 3;
         2: return 1;
         3: return 2;
         4: return 1;
         5: return 3;
         6: return 17;
         7: return 1;
         8: return 3;
         9: return 114;
         default: return 4;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   function automatic void check(string name, int cfg, logic [256:0] act, logic [256:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cfg%0d: got %h, expected %h", name, cfg, act, exp);
      end
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);

      typedef struct {
         logic [256:0] val;
         int           cyc;
         bit           lat;
      } exp_t;

      logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
      logic [W-1:0] a, b;
      logic [W:0]   sum;
      exp_t         q[$];

      pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .sub       (sub),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .sum       (sum)
      );

      // Reference: plain unsigned arithmetic; subtraction gives {a>=b, (a-b) mod 2^W}.
      function automatic logic [256:0] model(logic [W-1:0] x, logic [W-1:0] y, logic s);
         logic [256:0] ex, ey, m;
         ex = 257'(x);
         ey = 257'(y);
         if (!s)
            return ex + ey;
         m = (257'(1) << W) - 257'(1);
         return ((ex >= ey) ? (257'(1) << W) : 257'(0)) | ((ex - ey) & m);
      endfunction

      function automatic logic [W-1:0] rnd_op();
         logic [255:0] r;
         for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = $urandom;
         case ($urandom_range(0, 5))
            0: r = '0;
            1: r = '1;
            2: r = 256'd1;
            default: ;
         endcase
         return r[W-1:0];
      endfunction

      task automatic drive(input logic r, input logic v, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic s, input logic rdy, input bit lat);
         exp_t e;
         @(negedge clk);
         rst       = r;
         in_valid  = v;
         a         = x;
         b         = y;
         sub       = s;
         out_ready = rdy;
         #1;
         if (r) begin
            q.delete();
         end else if (v && in_ready) begin
            e.val = model(x, y, s);
            e.cyc = cyc;
            e.lat = lat;
            q.push_back(e);
         end
      endtask

      initial begin
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
         repeat (3) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         // corner beats back to back with exact latency expected
         drive(1'b0, 1'b1, '1, W'(1), 1'b0, 1'b1, 1'b1);
         drive(1'b0, 1'b1, W'(5), W'(7), 1'b1, 1'b1, 1'b1);
         drive(1'b0, 1'b1, W'(7), W'(5), 1'b1, 1'b1, 1'b1);
         drive(1'b0, 1'b1, W'(1), W'(1), 1'b0, 1'b1, 1'b1);
         drive(1'b0, 1'b1, W'(2), W'(2), 1'b0, 1'b1, 1'b1);
         drive(1'b0, 1'b1, W'(3), W'(3), 1'b0, 1'b1, 1'b1);
         drive(1'b0, 1'b1, '0, '1, 1'b1, 1'b1, 1'b1);
         repeat (S + 3) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         // downstream stall while new beats keep being offered
         for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, rnd_op(), rnd_op(), 1'(i % 2), 1'b1, 1'b0);
         repeat (S + 4) drive(1'b0, 1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         repeat (S + 6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         // reset with beats in flight
         for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, rnd_op(), rnd_op(), 1'b0, 1'b1, 1'b0);
         drive(1'b1, 1'b1, rnd_op(), rnd_op(), 1'b0, 1'b1, 1'b0);
         repeat (S + 4) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         // reset while stalled
         for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1, 1'b0);
         repeat (S + 3) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
         drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
         repeat (S + 4) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         // random traffic
         for (int i = 0; i < NCYC; i++)
            drive(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 99) < 85),
                  rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 80), 1'b0);
         repeat (S + 6) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
         check("leftover_beats", g, 257'(q.size()), 257'(0));
         done_cnt++;
      end

      initial begin
         bit         prev_stall;
         bit         prev_rst;
         logic [W:0] prev_sum;
         exp_t       e;
         prev_stall = 1'b0;
         prev_rst   = 1'b0;
         prev_sum   = '0;
         forever begin
            @(negedge clk);
            #2;
            if (prev_rst) begin
               check("rst_out_valid", g, 257'(out_valid), 257'(0));
               check("rst_sum", g, 257'(sum), 257'(0));
               check("rst_in_ready", g, 257'(in_ready), 257'(1));
            end else if (prev_stall) begin
               check("stall_out_valid", g, 257'(out_valid), 257'(1));
               check("stall_sum", g, 257'(sum), 257'(prev_sum));
            end
            if (!rst) begin
               check("in_ready", g, 257'(in_ready), 257'(!(out_valid && !out_ready)));
               if (out_valid && out_ready) begin
                  if (q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL unexpected_beat cfg%0d: got sum %h, expected no beat", g, sum);
                  end else begin
                     e = q.pop_front();
                     check("sum", g, 257'(sum), e.val);
                     if (e.lat)
                        check("latency", g, 257'(cyc - e.cyc), 257'(S + 1));
                  end
               end
            end
            prev_stall = !rst && out_valid && !out_ready;
            prev_rst   = rst;
            prev_sum   = sum;
         end
      end
   end

   initial begin
      for (int t = 0; t < 20000 && done_cnt < NCFG; t++)
         @(posedge clk);
      if (done_cnt < NCFG) begin
         miscompares++;
         $display("FAIL timeout: got %0d finished configs, expected %0d", done_cnt, NCFG);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
